gpio_bank: RTL and testbench
============================

Name: gpio_bank

Overview:
- Parametrised successor to the single-port memory-mapped GPIO IP on the SOC IO bus.
- Provides GPIO_WIDTH bidirectional pins with:
  - per-pin direction control;
  - atomic set/clear/toggle of outputs;
  - synchronised inputs with rising/falling edge detection;
  - sticky interrupt status with a single level irq output.
- Sits behind the IO decode. The SOC gates bus_wmask and bus_rstrb with its chip-select, exactly as for the existing GPIO IP.

Parameters:
- GPIO_WIDTH, 8, number of pins; legal range 1..32.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.
- DEBOUNCE_CYCLES, 16, stable-cycle count for the optional debounce; legal range 1..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- bus_addr  in  32  byte address; bus_addr[5:2] selects the register.
- bus_wdata  in  32  write data.
- bus_wmask  in  4  byte write enables; nonzero means write.
- bus_rstrb  in  1  read strobe.
- bus_rdata  out  32  registered read data.
- gpio_in  in  GPIO_WIDTH  asynchronous pin inputs.
- gpio_out  out  GPIO_WIDTH  output data register.
- gpio_oe  out  GPIO_WIDTH  output enables (DIR register).
- irq  out  1  interrupt request, level.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - All registers, synchroniser flops, edge-history flops, bus_rdata, gpio_out, gpio_oe and irq clear to 0 immediately.
  - Reset mid-operation discards pending edges and any pending read data.
- Register map (word index = bus_addr[5:2]):
  - 0 DATA_OUT, RW.
  - 1 DIR, RW; 1 = output.
  - 2 DATA_IN, RO; synchronised (optionally debounced) pin value.
  - 3 SET, WO; ones set DATA_OUT bits; reads 0.
  - 4 CLR, WO; ones clear DATA_OUT bits; reads 0.
  - 5 TGL, WO; ones invert DATA_OUT bits; reads 0.
  - 6 RISE_EN, RW.
  - 7 FALL_EN, RW.
  - 8 STATUS, R/W1C.
  - 9..15 read 0; writes to them are ignored.
- Writes:
  - Take effect at the clk edge where bus_wmask != 0.
  - Byte lane k is written only if bus_wmask[k]. This applies to SET/CLR/TGL/STATUS too; masked lanes are treated as zero.
  - Bits >= GPIO_WIDTH are ignored on write and read as 0.
- Reads:
  - When bus_rstrb is high, bus_rdata is loaded at that clk edge with the addressed register. Latency is 1 cycle.
  - bus_rdata holds its value until the next strobe.
  - If a read and a write hit the same register in the same cycle, the pre-write value is returned.
- Outputs: gpio_out = DATA_OUT and gpio_oe = DIR, both straight from flops. DATA_OUT is independent of DIR.
- Input path:
  - gpio_in passes through a SYNC_STAGES flop chain to give sync_in.
  - DATA_IN = sync_in (or the debounced value when the optional feature is enabled).
  - A pin change on gpio_in is visible in DATA_IN after SYNC_STAGES edges.
  - prev register tracks DATA_IN each cycle.
  - rise = DATA_IN & ~prev; fall = ~DATA_IN & prev.
- STATUS (sticky per bit):
  - Next value = (STATUS & ~w1c) | (rise & RISE_EN) | (fall & FALL_EN).
  - A set in the same cycle as a W1C of that bit wins; the bit stays 1.
  - Edges whose enable is 0 are never recorded. Enabling later does not retro-set a bit.
- irq: registered, irq <= |STATUS. It asserts 1 cycle after a STATUS bit sets and deasserts 1 cycle after the last bit clears.
- SET, CLR and TGL writes in consecutive cycles each act on the DATA_OUT already updated by the previous write. Nothing is lost.

Optional Feature:
- Macro: GPIO_BANK_DEBOUNCE_EN.
- Defined: each pin has a 16-bit counter.
  - Whenever sync_in[i] differs from the debounced bit, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced bit takes sync_in[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches DATA_IN or STATUS.
- Undefined: DATA_IN = sync_in, no counters are instantiated, and edge latency is SYNC_STAGES+1 cycles to STATUS.

Test Plan:
- Reset/readback:
  - Assert rst mid-run, then read all 16 indices → all 0, gpio_out=0, gpio_oe=0, irq=0.
  - Write DIR=0xFFFFFFFF with GPIO_WIDTH=8 → reads 0x000000FF.
- Atomic ops:
  - Write DATA_OUT=0x0F, SET=0x30, CLR=0x01, TGL=0x81 in consecutive cycles → gpio_out 0x0F, 0x3F, 0x3E, 0xBF.
  - Write with bus_wmask=4'b0010 and wdata=0xFFFF → only bits 15:8 are affected (none for width 8).
- Input latency: toggle gpio_in[3] 0→1 → DATA_IN bit3 reads 1 exactly SYNC_STAGES edges later. With RISE_EN=0x08, STATUS=0x08 one cycle after that and irq=1 on the following cycle.
- Edge selection: with RISE_EN=0 and FALL_EN=0x01, pulse gpio_in[0] high for 5 cycles → STATUS bit0 sets only on the falling edge. A rising edge alone leaves STATUS=0.
- W1C race: write STATUS=0x01 in the same cycle a new enabled edge on pin 0 is detected → bit0 stays 1 and irq stays 1. Writing 0x01 with no edge → bit0=0 and irq drops 1 cycle later.
- Debounce (GPIO_BANK_DEBOUNCE_EN, DEBOUNCE_CYCLES=16):
  - A 10-cycle glitch on gpio_in[2] → DATA_IN and STATUS unchanged.
  - A 40-cycle high → DATA_IN bit2=1 exactly SYNC_STAGES+16 edges after the pin change.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with per-pin direction control and
// atomic set/clear/toggle of the outputs. Inputs are synchronised and
// edge-detected, edges are latched into a sticky W1C status register,
// and a level irq is driven from that status.
// Optional input debounce is enabled by defining GPIO_BANK_DEBOUNCE_EN.
module gpio_bank #(
    parameter int unsigned GPIO_WIDTH      = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           bus_addr,
    input  logic [31:0]           bus_wdata,
    input  logic [3:0]            bus_wmask,
    input  logic                  bus_rstrb,
    output logic [31:0]           bus_rdata,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    localparam logic [3:0] IdxDataOut = 4'd0;
    localparam logic [3:0] IdxDir     = 4'd1;
    localparam logic [3:0] IdxDataIn  = 4'd2;
    localparam logic [3:0] IdxSet     = 4'd3;
    localparam logic [3:0] IdxClr     = 4'd4;
    localparam logic [3:0] IdxTgl     = 4'd5;
    localparam logic [3:0] IdxRiseEn  = 4'd6;
    localparam logic [3:0] IdxFallEn  = 4'd7;
    localparam logic [3:0] IdxStatus  = 4'd8;

    logic [GPIO_WIDTH-1:0] r_data_out;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_rise_en;
    logic [GPIO_WIDTH-1:0] r_fall_en;
    logic [GPIO_WIDTH-1:0] r_status;
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [GPIO_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic                  r_irq;
    logic [31:0]           r_rdata;

    logic [3:0]            w_idx;
    logic                  w_wr;
    logic [31:0]           w_lanes;
    logic [GPIO_WIDTH-1:0] w_lane_bits;
    logic [GPIO_WIDTH-1:0] w_wbits;
    logic [GPIO_WIDTH-1:0] w_sync_in;
    logic [GPIO_WIDTH-1:0] w_data_in;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [GPIO_WIDTH-1:0] w_w1c;
    logic [GPIO_WIDTH-1:0] w_data_out_d;
    logic [GPIO_WIDTH-1:0] w_dir_d;
    logic [GPIO_WIDTH-1:0] w_rise_en_d;
    logic [GPIO_WIDTH-1:0] w_fall_en_d;
    logic [GPIO_WIDTH-1:0] w_status_d;
    logic [31:0]           w_rd_val;
    logic                  w_unused_bus;

    assign w_idx       = bus_addr[5:2];
    assign w_wr        = |bus_wmask;
    assign w_lanes     = {{8{bus_wmask[3]}}, {8{bus_wmask[2]}},
                          {8{bus_wmask[1]}}, {8{bus_wmask[0]}}};
    // Masked-off lanes behave as zero data; bits above the pin count drop out.
    assign w_lane_bits = GPIO_WIDTH'(w_lanes);
    assign w_wbits     = GPIO_WIDTH'(bus_wdata & w_lanes);
    assign w_sync_in   = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_data_in & ~r_prev;
    assign w_fall      = ~w_data_in & r_prev;

    assign gpio_out  = r_data_out;
    assign gpio_oe   = r_dir;
    assign irq       = r_irq;
    assign bus_rdata = r_rdata;

    assign w_unused_bus = ^{bus_addr[31:6], bus_addr[1:0], bus_wdata, w_lanes};

    // Input synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

`ifdef GPIO_BANK_DEBOUNCE_EN
    localparam logic [15:0] DbLast = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0]           r_db_cnt [GPIO_WIDTH];
    logic [GPIO_WIDTH-1:0] r_db_val;

    // Per-pin debounce: accept a new level only after it has held steadily.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_val <= '0;
            for (int i = 0; i < GPIO_WIDTH; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < GPIO_WIDTH; i++) begin
                if (w_sync_in[i] != r_db_val[i]) begin
                    if (r_db_cnt[i] == DbLast) begin
                        r_db_val[i] <= w_sync_in[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    assign w_data_in = r_db_val;
`else
    logic [15:0] w_unused_db;

    assign w_unused_db = 16'(DEBOUNCE_CYCLES);
    assign w_data_in   = w_sync_in;
`endif

    // Register write decode and sticky status next-state.
    always_comb begin
        w_data_out_d = r_data_out;
        w_dir_d      = r_dir;
        w_rise_en_d  = r_rise_en;
        w_fall_en_d  = r_fall_en;
        w_w1c        = '0;
        if (w_wr) begin
            case (w_idx)
                IdxDataOut: w_data_out_d = (r_data_out & ~w_lane_bits) | w_wbits;
                IdxDir:     w_dir_d      = (r_dir & ~w_lane_bits) | w_wbits;
                IdxSet:     w_data_out_d = r_data_out | w_wbits;
                IdxClr:     w_data_out_d = r_data_out & ~w_wbits;
                IdxTgl:     w_data_out_d = r_data_out ^ w_wbits;
                IdxRiseEn:  w_rise_en_d  = (r_rise_en & ~w_lane_bits) | w_wbits;
                IdxFallEn:  w_fall_en_d  = (r_fall_en & ~w_lane_bits) | w_wbits;
                IdxStatus:  w_w1c        = w_wbits;
                default:    ;
            endcase
        end
        // New edges are ORed in after the clear so a simultaneous set wins.
        w_status_d = (r_status & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
    end

    // Read mux; sees pre-write register values.
    always_comb begin
        w_rd_val = '0;
        case (w_idx)
            IdxDataOut: w_rd_val = 32'(r_data_out);
            IdxDir:     w_rd_val = 32'(r_dir);
            IdxDataIn:  w_rd_val = 32'(w_data_in);
            IdxRiseEn:  w_rd_val = 32'(r_rise_en);
            IdxFallEn:  w_rd_val = 32'(r_fall_en);
            IdxStatus:  w_rd_val = 32'(r_status);
            default:    w_rd_val = '0;
        endcase
    end

    // Control/status registers, edge history, irq and read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_dir      <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_status   <= '0;
            r_prev     <= '0;
            r_irq      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_data_out <= w_data_out_d;
            r_dir      <= w_dir_d;
            r_rise_en  <= w_rise_en_d;
            r_fall_en  <= w_fall_en_d;
            r_status   <= w_status_d;
            r_prev     <= w_data_in;
            r_irq      <= |r_status;
            if (bus_rstrb) r_rdata <= w_rd_val;
        end
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank; read results go through a
// scoreboard queue filled when the strobe is issued.
module tb_gpio_bank;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;
    localparam int unsigned D = 16;

    localparam logic [3:0] IDX_DATA_OUT = 4'd0;
    localparam logic [3:0] IDX_DIR      = 4'd1;
    localparam logic [3:0] IDX_DATA_IN  = 4'd2;
    localparam logic [3:0] IDX_SET      = 4'd3;
    localparam logic [3:0] IDX_CLR      = 4'd4;
    localparam logic [3:0] IDX_TGL      = 4'd5;
    localparam logic [3:0] IDX_RISE_EN  = 4'd6;
    localparam logic [3:0] IDX_FALL_EN  = 4'd7;
    localparam logic [3:0] IDX_STATUS   = 4'd8;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic [3:0]    bus_wmask;
    logic          bus_rstrb;
    logic [31:0]   bus_rdata;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [31:0]   q_exp[$];
    string         q_tag[$];

    gpio_bank #(
        .GPIO_WIDTH     (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_wmask(bus_wmask),
        .bus_rstrb(bus_rstrb),
        .bus_rdata(bus_rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] idx, input logic [31:0] data, input logic [3:0] mask);
        bus_addr  = {26'd0, idx, 2'b00};
        bus_wdata = data;
        bus_wmask = mask;
        cyc();
        bus_wmask = 4'b0000;
    endtask

    task automatic pop_check();
        logic [31:0] e;
        string       t;
        if (q_exp.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected none", bus_rdata);
        end else begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            check(t, bus_rdata, e);
        end
    endtask

    // Read one register (optionally with a simultaneous write) and score the result.
    task automatic rw(input logic [3:0] idx, input logic [31:0] exp, input string tag,
                      input logic [31:0] data, input logic [3:0] mask);
        bus_addr  = {26'd0, idx, 2'b00};
        bus_wdata = data;
        bus_wmask = mask;
        bus_rstrb = 1'b1;
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        cyc();
        bus_rstrb = 1'b0;
        bus_wmask = 4'b0000;
        pop_check();
    endtask

    task automatic rd(input logic [3:0] idx, input logic [31:0] exp, input string tag);
        rw(idx, exp, tag, 32'd0, 4'b0000);
    endtask

    initial begin
        rst       = 1'b1;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_wmask = '0;
        bus_rstrb = 1'b0;
        gpio_in   = '0;
        repeat (2) cyc();
        check("por_gpio_out", 32'(gpio_out), 32'h0);
        check("por_gpio_oe", 32'(gpio_oe), 32'h0);
        check("por_irq", 32'(irq), 32'h0);
        check("por_rdata", bus_rdata, 32'h0);
        rst = 1'b0;

        // Load state, then reset mid-run.
        wr(IDX_DIR, 32'hFFFF_FFFF, 4'hF);
        wr(IDX_DATA_OUT, 32'h0000_00A5, 4'hF);
        wr(IDX_RISE_EN, 32'h0000_00FF, 4'hF);
        gpio_in = 8'h5A;
        repeat (4) cyc();
        check("pre_rst_irq", 32'(irq), 32'h1);
        rd(IDX_DATA_OUT, 32'hA5, "pre_rst_data_out");
        #3;
        rst     = 1'b1;
        gpio_in = '0;
        #1;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        for (int i = 0; i < 16; i++) rd(4'(i), 32'h0, $sformatf("rst_read_%0d", i));
        check("rst_irq_after", 32'(irq), 32'h0);

        // Width clipping.
        wr(IDX_DIR, 32'hFFFF_FFFF, 4'hF);
        rd(IDX_DIR, 32'h0000_00FF, "dir_clip");
        check("gpio_oe_ff", 32'(gpio_oe), 32'hFF);

        // Atomic ops in consecutive cycles.
        wr(IDX_DATA_OUT, 32'h0F, 4'hF);
        check("atomic_wr", 32'(gpio_out), 32'h0F);
        wr(IDX_SET, 32'h30, 4'hF);
        check("atomic_set", 32'(gpio_out), 32'h3F);
        wr(IDX_CLR, 32'h01, 4'hF);
        check("atomic_clr", 32'(gpio_out), 32'h3E);
        wr(IDX_TGL, 32'h81, 4'hF);
        check("atomic_tgl", 32'(gpio_out), 32'hBF);
        rd(IDX_SET, 32'h0, "set_reads0");
        rd(IDX_CLR, 32'h0, "clr_reads0");
        rd(IDX_TGL, 32'h0, "tgl_reads0");

        // Byte lanes.
        wr(IDX_DATA_OUT, 32'h0000_FFFF, 4'b0010);
        check("lane1_only", 32'(gpio_out), 32'hBF);
        wr(IDX_DATA_OUT, 32'h0000_1200, 4'b0001);
        check("lane0_zero", 32'(gpio_out), 32'h00);
        wr(IDX_SET, 32'hFFFF_FF00, 4'b1110);
        check("set_masked", 32'(gpio_out), 32'h00);
        wr(IDX_SET, 32'h0000_00FF, 4'b0001);
        check("set_lane0", 32'(gpio_out), 32'hFF);

        // Read and write to the same register in one cycle returns old value.
        rw(IDX_DATA_OUT, 32'hFF, "rw_same_cycle", 32'h11, 4'hF);
        check("rw_new_value", 32'(gpio_out), 32'h11);
        wr(4'd9, 32'hFFFF_FFFF, 4'hF);
        rd(4'd9, 32'h0, "idx9_ignored");
        rd(IDX_DATA_OUT, 32'h11, "idx9_no_alias");

`ifndef GPIO_BANK_DEBOUNCE_EN
        // Input latency and rising-edge status.
        wr(IDX_RISE_EN, 32'h08, 4'hF);
        gpio_in = 8'h08;
        rd(IDX_DATA_IN, 32'h00, "lat_e1");
        check("lat_irq_e1", 32'(irq), 32'h0);
        rd(IDX_DATA_IN, 32'h00, "lat_e2");
        rd(IDX_DATA_IN, 32'h08, "lat_e3");
        check("lat_irq_e3", 32'(irq), 32'h0);
        rd(IDX_STATUS, 32'h08, "lat_status");
        check("lat_irq_e4", 32'(irq), 32'h1);
        wr(IDX_STATUS, 32'h08, 4'hF);
        check("w1c_irq_hold", 32'(irq), 32'h1);
        rd(IDX_STATUS, 32'h0, "w1c_status0");
        check("w1c_irq_drop", 32'(irq), 32'h0);

        // Falling edge only.
        wr(IDX_RISE_EN, 32'h00, 4'hF);
        wr(IDX_FALL_EN, 32'h01, 4'hF);
        gpio_in = 8'h09;
        for (int i = 0; i < 5; i++) rd(IDX_STATUS, 32'h0, $sformatf("rise_ignored_%0d", i));
        gpio_in = 8'h08;
        rd(IDX_STATUS, 32'h0, "fall_f1");
        rd(IDX_STATUS, 32'h0, "fall_f2");
        rd(IDX_STATUS, 32'h0, "fall_f3");
        check("fall_irq_f3", 32'(irq), 32'h0);
        rd(IDX_STATUS, 32'h1, "fall_f4");
        check("fall_irq_f4", 32'(irq), 32'h1);

        // W1C racing a new edge: the edge wins.
        gpio_in = 8'h09;
        repeat (4) cyc();
        rd(IDX_STATUS, 32'h1, "sticky");
        gpio_in = 8'h08;
        cyc();
        cyc();
        wr(IDX_STATUS, 32'h01, 4'hF);
        check("race_irq", 32'(irq), 32'h1);
        rd(IDX_STATUS, 32'h1, "race_status");
        check("race_irq2", 32'(irq), 32'h1);
        wr(IDX_STATUS, 32'h01, 4'b0010);
        rd(IDX_STATUS, 32'h1, "w1c_lane_masked");
        wr(IDX_STATUS, 32'h01, 4'hF);
        check("clr_irq_hold", 32'(irq), 32'h1);
        rd(IDX_STATUS, 32'h0, "clr_status");
        check("clr_irq_drop", 32'(irq), 32'h0);

        // Enabling later does not record a past edge.
        wr(IDX_RISE_EN, 32'h08, 4'hF);
        repeat (2) cyc();
        rd(IDX_STATUS, 32'h0, "no_retro");
`else
        // Debounce: short glitch filtered, long level accepted.
        wr(IDX_RISE_EN, 32'h04, 4'hF);
        wr(IDX_FALL_EN, 32'h04, 4'hF);
        gpio_in = 8'h04;
        repeat (10) cyc();
        gpio_in = 8'h00;
        repeat (30) cyc();
        rd(IDX_DATA_IN, 32'h0, "glitch_data_in");
        rd(IDX_STATUS, 32'h0, "glitch_status");
        check("glitch_irq", 32'(irq), 32'h0);
        gpio_in = 8'h04;
        for (int k = 1; k <= 20; k++)
            rd(IDX_DATA_IN, (k >= int'(S + D + 1)) ? 32'h04 : 32'h00, $sformatf("db_e%0d", k));
        repeat (3) cyc();
        rd(IDX_STATUS, 32'h04, "db_status");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
